// File: rtl/lol_pkg.sv
// Shared letter codes, symbol constants, FSM state type and body helpers for the L/O/Y writer.
// Used by lol_req_fifo and lol_writer; the LOL_WRITER_FIFO_EN macro is consumed by those files.
package lol_pkg;

  localparam logic [1:0] LOL_L       = 2'b00;
  localparam logic [1:0] LOL_O       = 2'b01;
  localparam logic [1:0] LOL_Y       = 2'b10;
  localparam logic [1:0] LOL_INVALID = 2'b11;

  localparam logic [2:0] SYM_SEP = 3'b000;
  localparam logic [2:0] SYM_L1  = 3'b111;
  localparam logic [2:0] SYM_L2  = 3'b001;
  localparam logic [2:0] SYM_O1  = 3'b111;
  localparam logic [2:0] SYM_O2  = 3'b101;
  localparam logic [2:0] SYM_O3  = 3'b111;
  localparam logic [2:0] SYM_Y1  = 3'b100;
  localparam logic [2:0] SYM_Y2  = 3'b011;
  localparam logic [2:0] SYM_Y3  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_TERM
  } lol_state_t;

  function automatic logic [1:0] body_len(input logic [1:0] letter);
    return (letter == LOL_L) ? 2'd2 : 2'd3;
  endfunction

  // Symbol shown on the bits output while in a given state; IDLE and TERM are separators.
  function automatic logic [2:0] body_symbol(input lol_state_t st, input logic [1:0] letter);
    logic [2:0] sym;
    sym = SYM_SEP;
    case (letter)
      LOL_L: begin
        case (st)
          ST_S1:   sym = SYM_L1;
          ST_S2:   sym = SYM_L2;
          default: sym = SYM_SEP;
        endcase
      end
      LOL_O: begin
        case (st)
          ST_S1:   sym = SYM_O1;
          ST_S2:   sym = SYM_O2;
          ST_S3:   sym = SYM_O3;
          default: sym = SYM_SEP;
        endcase
      end
      LOL_Y: begin
        case (st)
          ST_S1:   sym = SYM_Y1;
          ST_S2:   sym = SYM_Y2;
          ST_S3:   sym = SYM_Y3;
          default: sym = SYM_SEP;
        endcase
      end
      default: sym = SYM_SEP;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/lol_req_fifo.sv
// Request queue for lol_writer: a FIFO_DEPTH-entry circular buffer when LOL_WRITER_FIFO_EN is
// defined, otherwise a single holding register.
module lol_req_fifo
  import lol_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop,
  output logic [1:0] pop_data,
  output logic       full,
  output logic       empty
);

`ifdef LOL_WRITER_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_en;
  logic             pop_en;

  assign push_en  = push & ~full;
  assign pop_en   = pop & ~empty;
  assign full     = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end
`else
  logic [1:0]                  hold;
  logic                        hold_valid;
  logic [$clog2(FIFO_DEPTH):0] unused_depth;

  assign unused_depth = '0;
  assign full         = hold_valid;
  assign empty        = ~hold_valid;
  assign pop_data     = hold;

  // A push in the same cycle as a pop refills the register, so it stays valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= LOL_L;
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= push_data;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/lol_writer.sv
// L/O/Y symbol-stream transmitter: queues letter requests and serialises each as its body plus
// a 000 terminator. Queue style selected by LOL_WRITER_FIFO_EN (see lol_req_fifo).
module lol_writer
  import lol_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [1:0] req_letter,
  output logic       req_ready,
  output logic [2:0] bits,
  output logic       busy,
  output logic       done,
  output logic       err
);

  lol_state_t state;
  lol_state_t next_state;
  logic [1:0] cur_letter;
  logic [1:0] next_letter;
  logic [2:0] next_bits;
  logic       next_err;
  logic       push;
  logic       pop;
  logic [1:0] q_data;
  logic       q_full;
  logic       q_empty;

  lol_req_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(req_letter),
    .pop      (pop),
    .pop_data (q_data),
    .full     (q_full),
    .empty    (q_empty)
  );

`ifdef LOL_WRITER_FIFO_EN
  assign req_ready = ~q_full;
`else
  assign req_ready = ~q_full | pop;
`endif

  assign push = req_valid & req_ready;
  assign done = (state == ST_TERM);
  assign busy = (state != ST_IDLE) | ~q_empty;

  // Separator states consume the next request; invalid codes are dropped with an err pulse.
  always_comb begin
    next_state  = state;
    next_letter = cur_letter;
    next_err    = 1'b0;
    pop         = 1'b0;
    case (state)
      ST_IDLE, ST_TERM: begin
        next_state = ST_IDLE;
        if (!q_empty) begin
          pop = 1'b1;
          if (q_data == LOL_INVALID) begin
            next_err = 1'b1;
          end else begin
            next_state  = ST_S1;
            next_letter = q_data;
          end
        end
      end
      ST_S1:   next_state = ST_S2;
      ST_S2:   next_state = (body_len(cur_letter) == 2'd2) ? ST_TERM : ST_S3;
      ST_S3:   next_state = ST_TERM;
      default: next_state = ST_IDLE;
    endcase
    next_bits = body_symbol(next_state, next_letter);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_letter <= LOL_L;
      bits       <= SYM_SEP;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      cur_letter <= next_letter;
      bits       <= next_bits;
      err        <= next_err;
    end
  end

endmodule

// File: tb/tb_lol_writer.sv
// Self-checking bench for lol_writer: a symbol-stream model checked every cycle plus a few
// hand-computed letter waveforms. Follows LOL_WRITER_FIFO_EN for queue capacity.
module tb_lol_writer;

  localparam int DEPTH = 4;
  localparam logic [1:0] K_IDLE = 2'd0;
  localparam logic [1:0] K_BODY = 2'd1;
  localparam logic [1:0] K_TERM = 2'd2;

  typedef struct packed {
    logic [2:0] sym;
    logic [1:0] kind;
    logic       err;
  } slot_t;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic [1:0] req_letter;
  logic       req_ready;
  logic [2:0] bits;
  logic       busy;
  logic       done;
  logic       err;

  int vectors;
  int miscompares;
  int err_seen;
  int done_seen;
  int body_seen;

  slot_t      script[$];
  logic [1:0] pending[$];
  slot_t      cur;

  lol_writer #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_letter(req_letter),
    .req_ready (req_ready),
    .bits      (bits),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmpField(input string name, input logic [2:0] got, input logic [2:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic checkOutput(input logic [2:0] exp_bits, input logic exp_done, input logic exp_err,
                             input logic exp_busy, input logic exp_ready);
    vectors++;
    cmpField("bits", bits, exp_bits);
    cmpField("done", {2'b00, done}, {2'b00, exp_done});
    cmpField("err", {2'b00, err}, {2'b00, exp_err});
    cmpField("busy", {2'b00, busy}, {2'b00, exp_busy});
    cmpField("req_ready", {2'b00, req_ready}, {2'b00, exp_ready});
  endtask

  task automatic checkLiteral(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Queue the cycles a letter occupies on the wire: body symbols, then a 000 terminator.
  task automatic pushBody(input logic [1:0] code);
    case (code)
      2'd0: begin
        script.push_back({3'b111, K_BODY, 1'b0});
        script.push_back({3'b001, K_BODY, 1'b0});
      end
      2'd1: begin
        script.push_back({3'b111, K_BODY, 1'b0});
        script.push_back({3'b101, K_BODY, 1'b0});
        script.push_back({3'b111, K_BODY, 1'b0});
      end
      default: begin
        script.push_back({3'b100, K_BODY, 1'b0});
        script.push_back({3'b011, K_BODY, 1'b0});
        script.push_back({3'b100, K_BODY, 1'b0});
      end
    endcase
    script.push_back({3'b000, K_TERM, 1'b0});
  endtask

  // Model: whenever the wire shows a separator, one queued request is consumed.
  always @(negedge clk) begin : compare_proc
    logic       popping;
    logic       exp_ready;
    logic       exp_busy;
    logic [1:0] code;
    if (!reset_n) begin
      pending.delete();
      script.delete();
      cur = {3'b000, K_IDLE, 1'b0};
    end
    popping = reset_n && (cur.kind != K_BODY) && (pending.size() > 0);
`ifdef LOL_WRITER_FIFO_EN
    exp_ready = (pending.size() < DEPTH);
`else
    exp_ready = (pending.size() == 0) || popping;
`endif
    exp_busy = (cur.kind != K_IDLE) || (pending.size() > 0);
    checkOutput(cur.sym, cur.kind == K_TERM, cur.err, exp_busy, exp_ready);
    if (err)          err_seen++;
    if (done)         done_seen++;
    if (bits != 3'd0) body_seen++;
    if (reset_n) begin
      if (popping) begin
        code = pending.pop_front();
        if (code == 2'd3) script.push_back({3'b000, K_IDLE, 1'b1});
        else              pushBody(code);
      end
      if (req_valid && exp_ready) pending.push_back(req_letter);
      if (script.size() > 0) cur = script.pop_front();
      else                   cur = {3'b000, K_IDLE, 1'b0};
    end
  end

  // Present a request from the posedge+2 phase and hold it until the handshake completes.
  task automatic applyStimulus(input logic [1:0] letter);
    logic acc;
    acc        = 1'b0;
    req_valid  = 1'b1;
    req_letter = letter;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake: req_ready stayed 0 for 64 cycles, required 1");
    end
  endtask

  task automatic applyIdle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic captureBits(input int n, output logic [31:0] got_bits, output logic [31:0] got_done);
    got_bits = '0;
    got_done = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got_bits = (got_bits << 3) | 32'(bits);
      got_done = (got_done << 1) | 32'(done);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] gb;
    logic [31:0] gd;
    int          e0;
    int          d0;
    int          b0;
    int          guard;
    vectors     = 0;
    miscompares = 0;
    err_seen    = 0;
    done_seen   = 0;
    body_seen   = 0;
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_letter  = 2'd0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyIdle(3);

    // Single L: 000 on the cycle after acceptance, then 111, 001, terminator with done.
    applyStimulus(2'd0);
    req_valid = 1'b0;
    captureBits(4, gb, gd);
    checkLiteral("L waveform", gb, 32'h1C8);
    checkLiteral("L done", gd, 32'h1);
    applyIdle(6);

    // O then Y back to back with no gap between the letters.
    applyStimulus(2'd1);
    applyStimulus(2'd2);
    req_valid = 1'b0;
    captureBits(8, gb, gd);
    checkLiteral("OY waveform", gb, 32'hF788E0);
    checkLiteral("OY done", gd, 32'h11);
    applyIdle(6);

    // Invalid code between two L requests.
    e0 = err_seen;
    d0 = done_seen;
    b0 = body_seen;
    applyStimulus(2'd0);
    applyStimulus(2'd3);
    applyStimulus(2'd0);
    applyIdle(20);
    checkLiteral("invalid err pulses", 32'(err_seen - e0), 32'd1);
    checkLiteral("invalid done pulses", 32'(done_seen - d0), 32'd2);
    checkLiteral("invalid body cycles", 32'(body_seen - b0), 32'd4);

    // Reset asserted while the 101 of an O is on the wire, with a Y still queued.
    applyStimulus(2'd1);
    applyStimulus(2'd2);
    req_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bits != 3'b101 && guard < 20);
    checkLiteral("reached O middle", 32'(bits), 32'h5);
    #1;
    reset_n = 1'b0;
    #1;
    checkLiteral("reset bits", 32'(bits), 32'h0);
    checkLiteral("reset busy", 32'(busy), 32'h0);
    checkLiteral("reset ready", 32'(req_ready), 32'h1);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyIdle(2);
    applyStimulus(2'd0);
    req_valid = 1'b0;
    captureBits(4, gb, gd);
    checkLiteral("L after reset", gb, 32'h1C8);
    applyIdle(6);

    // Randomised traffic including invalid codes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        req_valid = 1'b0;
        reset_n   = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #2;
        reset_n = 1'b1;
      end else begin
        req_valid  = ($urandom_range(0, 99) < 60);
        req_letter = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        @(posedge clk);
        #2;
      end
    end
    applyIdle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
